controle_temporizador: RTL and testbench

//  Countdown-timer controller that sequences the 7-segment decoder block: owns the
//  2-bit run state, a BCD count (dez 0..3, unid 0..9, max 39) and the digit scan.

---
 rtl/controle_temporizador.sv | 216 +++++++++++++++++++++
 tb/tb_controle_temporizador.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/controle_temporizador.sv
// Countdown-timer controller for the 7-segment decoder: run state, BCD count 00..39,
// and a free-running one-hot digit scan that time-shares the segment bus.
module controle_temporizador #(
   parameter int DIV_TICK = 50_000_000,
   parameter int DIV_SCAN = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iniciar,
   input  logic       pausar,
   input  logic       carregar,
   input  logic [1:0] dez_carga,
   input  logic [3:0] unid_carga,
   output logic [1:0] estado,
   output logic [1:0] dez,
   output logic [3:0] unid,
   output logic [2:0] digito,
   output logic       fim
);

   localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
   localparam int SW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV_TICK - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(DIV_SCAN - 1);

   typedef enum logic [1:0] {
      PARADO   = 2'b00,
      CONTANDO = 2'b01,
      PAUSA    = 2'b10,
      FIM      = 2'b11
   } estado_t;

   estado_t       estado_r, estado_s;
   logic [1:0]    dez_r, dez_s;
   logic [3:0]    unid_r, unid_s;
   logic [TW-1:0] tick_r, tick_s;
   logic          fim_r, fim_s;
   logic [SW-1:0] scan_r, scan_s;
   logic [2:0]    digito_r, digito_s;

   logic          count_zero_s;
   logic          step_s;
   logic          step_to_zero_s;
   logic [1:0]    dez_dec_s;
   logic [3:0]    unid_dec_s;

   // Units digit of a load request, clamped into BCD range.
   function automatic logic [3:0] satura_unid(input logic [3:0] v);
      if (v > 4'd9) begin
         return 4'd9;
      end else begin
         return v;
      end
   endfunction

   // Single BCD down-step of the current count with units borrow.
   always_comb begin
      count_zero_s   = (dez_r == 2'd0) && (unid_r == 4'd0);
      step_s         = (tick_r == TICK_LAST);
      step_to_zero_s = (dez_r == 2'd0) && (unid_r == 4'd1);
      if (unid_r == 4'd0) begin
         unid_dec_s = 4'd9;
         dez_dec_s  = dez_r - 2'd1;
      end else begin
         unid_dec_s = unid_r - 4'd1;
         dez_dec_s  = dez_r;
      end
   end

   // Next-state logic for run state, count, tick divider and end pulse.
   always_comb begin
      estado_s = estado_r;
      dez_s    = dez_r;
      unid_s   = unid_r;
      tick_s   = tick_r;
      fim_s    = 1'b0;
      case (estado_r)
         PARADO: begin
            if (carregar) begin
               dez_s  = dez_carga;
               unid_s = satura_unid(unid_carga);
            end else if (iniciar && !count_zero_s) begin
               estado_s = CONTANDO;
               tick_s   = {TW{1'b0}};
            end else begin
               estado_s = PARADO;
            end
         end
         CONTANDO: begin
            if (step_s) begin
               tick_s = {TW{1'b0}};
               if (!count_zero_s) begin
                  dez_s  = dez_dec_s;
                  unid_s = unid_dec_s;
               end else begin
                  dez_s  = 2'd0;
                  unid_s = 4'd0;
               end
               // Reaching 00 outranks a simultaneous pause request.
               if (step_to_zero_s || count_zero_s) begin
                  estado_s = FIM;
                  fim_s    = 1'b1;
               end else if (pausar) begin
                  estado_s = PAUSA;
               end else begin
                  estado_s = CONTANDO;
               end
            end else if (pausar) begin
               estado_s = PAUSA;
            end else begin
               tick_s = tick_r + TW'(1);
            end
         end
         PAUSA: begin
            if (iniciar && !pausar) begin
               estado_s = CONTANDO;
            end else begin
               estado_s = PAUSA;
            end
         end
         FIM: begin
            if (carregar) begin
               dez_s    = dez_carga;
               unid_s   = satura_unid(unid_carga);
               estado_s = PARADO;
            end else if (iniciar) begin
               estado_s = PARADO;
            end else begin
               dez_s  = 2'd0;
               unid_s = 4'd0;
            end
         end
         default: begin
            estado_s = PARADO;
            dez_s    = 2'd0;
            unid_s   = 4'd0;
            tick_s   = {TW{1'b0}};
         end
      endcase
   end

   // Free-running digit scan, independent of the run state.
   always_comb begin
      if (scan_r == SCAN_LAST) begin
         scan_s   = {SW{1'b0}};
         digito_s = {digito_r[1:0], digito_r[2]};
      end else begin
         scan_s   = scan_r + SW'(1);
         digito_s = digito_r;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_r <= PARADO;
         dez_r    <= 2'd0;
         unid_r   <= 4'd0;
         tick_r   <= {TW{1'b0}};
         fim_r    <= 1'b0;
      end else begin
         estado_r <= estado_s;
         dez_r    <= dez_s;
         unid_r   <= unid_s;
         tick_r   <= tick_s;
         fim_r    <= fim_s;
      end
   end

   // Scan registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_r   <= {SW{1'b0}};
         digito_r <= 3'b001;
      end else begin
         scan_r   <= scan_s;
         digito_r <= digito_s;
      end
   end

   assign estado = estado_r;
   assign dez    = dez_r;
   assign unid   = unid_r;
   assign digito = digito_r;
   assign fim    = fim_r;

   controle_temporizador_chk u_chk (
      .clk    (clk),
      .rst    (rst),
      .estado (estado_r),
      .dez    (dez_r),
      .unid   (unid_r),
      .digito (digito_r),
      .fim    (fim_r)
   );

endmodule

// Invariants of the timer outputs: one-hot scan, BCD range, single-cycle end pulse.
module controle_temporizador_chk (
   input logic       clk,
   input logic       rst,
   input logic [1:0] estado,
   input logic [1:0] dez,
   input logic [3:0] unid,
   input logic [2:0] digito,
   input logic       fim
);

   a_digito_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(digito));
   a_unid_bcd:      assert property (@(posedge clk) disable iff (rst) unid <= 4'd9);
   a_fim_estado:    assert property (@(posedge clk) disable iff (rst) fim |-> (estado == 2'b11));
   a_fim_pulse:     assert property (@(posedge clk) disable iff (rst) fim |=> !fim);
   a_dez_known:     assert property (@(posedge clk) disable iff (rst) !$isunknown(dez));

endmodule

// File: tb/tb_controle_temporizador.sv
// Directed bench for controle_temporizador (DIV_TICK=4, DIV_SCAN=2) with a queued
// scoreboard: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_controle_temporizador;

   logic       clk = 1'b0;
   logic       rst;
   logic       iniciar;
   logic       pausar;
   logic       carregar;
   logic [1:0] dez_carga;
   logic [3:0] unid_carga;
   logic [1:0] estado;
   logic [1:0] dez;
   logic [3:0] unid;
   logic [2:0] digito;
   logic       fim;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  e;
      logic [1:0]  d;
      logic [3:0]  u;
      logic        f;
      logic [2:0]  dg;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    cyc = 0;
   int    scan_k = 0;
   int    n_vec = 0;
   int    n_err = 0;

   controle_temporizador #(.DIV_TICK(4), .DIV_SCAN(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .iniciar    (iniciar),
      .pausar     (pausar),
      .carregar   (carregar),
      .dez_carga  (dez_carga),
      .unid_carga (unid_carga),
      .estado     (estado),
      .dez        (dez),
      .unid       (unid),
      .digito     (digito),
      .fim        (fim)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (rst) scan_k = 0;
      else     scan_k = scan_k + 1;
   endtask

   // Expected outputs for the current cycle; digit select follows (k/2) mod 3 since reset.
   task automatic esperar(input string nm, input logic [1:0] e, input int cnt, input logic f);
      exp_t x;
      x.cyc = cyc;
      x.e   = e;
      x.d   = 2'(cnt / 10);
      x.u   = 4'(cnt % 10);
      x.f   = f;
      x.dg  = 3'b001 << ((scan_k / 2) % 3);
      sb_q.push_back(x);
      nm_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      exp_t  x;
      string nm;
      while (sb_q.size() > 0 && int'(sb_q[0].cyc) <= cyc) begin
         x  = sb_q.pop_front();
         nm = nm_q.pop_front();
         n_vec = n_vec + 1;
         if (int'(x.cyc) < cyc) begin
            n_err = n_err + 1;
            $display("FAIL %s: stale entry for cycle %0d checked at cycle %0d", nm, x.cyc, cyc);
         end else if (estado !== x.e || dez !== x.d || unid !== x.u || fim !== x.f || digito !== x.dg) begin
            n_err = n_err + 1;
            $display("FAIL %s @%0d: got estado=%b dez=%0d unid=%0d fim=%b digito=%b, want estado=%b dez=%0d unid=%0d fim=%b digito=%b",
                     nm, cyc, estado, dez, unid, fim, digito, x.e, x.d, x.u, x.f, x.dg);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; iniciar = 1'b0; pausar = 1'b0; carregar = 1'b0;
      dez_carga = 2'd0; unid_carga = 4'd0;
      cycle(); esperar("reset", 2'b00, 0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin cycle(); esperar("scan_idle", 2'b00, 0, 1'b0); end

      carregar = 1'b1; dez_carga = 2'd1; unid_carga = 4'd12;
      cycle(); esperar("load_sat", 2'b00, 19, 1'b0);
      carregar = 1'b0; iniciar = 1'b1;
      cycle(); esperar("start", 2'b01, 19, 1'b0);
      iniciar = 1'b0;
      for (int s = 18; s >= 9; s--) begin
         for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, s + 1, 1'b0); end
         cycle(); esperar("count_step", 2'b01, s, 1'b0);
      end

      cycle(); esperar("pre_pause", 2'b01, 9, 1'b0);
      cycle(); esperar("pre_pause", 2'b01, 9, 1'b0);
      pausar = 1'b1;
      for (int i = 0; i < 5; i++) begin cycle(); esperar("pause_frozen", 2'b10, 9, 1'b0); end
      pausar = 1'b0; carregar = 1'b1; dez_carga = 2'd3; unid_carga = 4'd9;
      cycle(); esperar("load_in_pause", 2'b10, 9, 1'b0);
      carregar = 1'b0; iniciar = 1'b1; pausar = 1'b1;
      cycle(); esperar("both_in_pause", 2'b10, 9, 1'b0);
      pausar = 1'b0;
      cycle(); esperar("resume", 2'b01, 9, 1'b0);
      iniciar = 1'b0;
      cycle(); esperar("resume_hold", 2'b01, 9, 1'b0);
      cycle(); esperar("resume_step", 2'b01, 8, 1'b0);

      carregar = 1'b1; dez_carga = 2'd3; unid_carga = 4'd9;
      cycle(); esperar("load_ignored", 2'b01, 8, 1'b0);
      carregar = 1'b0;
      cycle(); esperar("count_hold", 2'b01, 8, 1'b0);
      cycle(); esperar("count_hold", 2'b01, 8, 1'b0);
      cycle(); esperar("count_step", 2'b01, 7, 1'b0);

      for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, 7, 1'b0); end
      pausar = 1'b1;
      cycle(); esperar("step_and_pause", 2'b10, 6, 1'b0);
      pausar = 1'b0; iniciar = 1'b1;
      cycle(); esperar("resume2", 2'b01, 6, 1'b0);
      iniciar = 1'b0;
      for (int s = 5; s >= 1; s--) begin
         for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, s + 1, 1'b0); end
         cycle(); esperar("count_step", 2'b01, s, 1'b0);
      end
      for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, 1, 1'b0); end
      pausar = 1'b1;
      cycle(); esperar("fim_wins", 2'b11, 0, 1'b1);
      pausar = 1'b0;
      cycle(); esperar("fim_once", 2'b11, 0, 1'b0);
      cycle(); esperar("fim_hold", 2'b11, 0, 1'b0);
      iniciar = 1'b1;
      cycle(); esperar("fim_to_parado", 2'b00, 0, 1'b0);
      cycle(); esperar("start_zero_ignored", 2'b00, 0, 1'b0);

      carregar = 1'b1; dez_carga = 2'd0; unid_carga = 4'd2;
      cycle(); esperar("load_priority", 2'b00, 2, 1'b0);
      carregar = 1'b0;
      cycle(); esperar("start_02", 2'b01, 2, 1'b0);
      iniciar = 1'b0;
      for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, 2, 1'b0); end
      cycle(); esperar("count_step", 2'b01, 1, 1'b0);
      for (int j = 0; j < 3; j++) begin cycle(); esperar("count_hold", 2'b01, 1, 1'b0); end
      cycle(); esperar("fim_pulse", 2'b11, 0, 1'b1);
      cycle(); esperar("fim_drop", 2'b11, 0, 1'b0);

      carregar = 1'b1; iniciar = 1'b1; dez_carga = 2'd2; unid_carga = 4'd5;
      cycle(); esperar("fim_load", 2'b00, 25, 1'b0);
      carregar = 1'b0;
      cycle(); esperar("start_25", 2'b01, 25, 1'b0);
      iniciar = 1'b0;
      cycle(); esperar("count_hold", 2'b01, 25, 1'b0);
      rst = 1'b1;
      cycle(); esperar("rst_mid_count", 2'b00, 0, 1'b0);
      rst = 1'b0;
      cycle(); esperar("after_rst", 2'b00, 0, 1'b0);
      cycle(); esperar("after_rst", 2'b00, 0, 1'b0);

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_err = n_err + 1;
         $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
